// File: rtl/mod_addsub_lanes.sv
// mod_addsub_lanes: LANES-wide modular adder/subtractor sharing one modulus
// per transaction, behind a two-stage valid/ready elastic pipeline.
//   S1: raw K+1-bit sum or borrow-extended difference per lane, plus op and q.
//   S2: single conditional correction by q into [0, q), registered to out_res.
// Optional build macro MOD_ADDSUB_RANGE_CHECK_EN adds out_err, flagging any
// transaction with a lane operand >= q or with q < 2. Results are unaffected.
// Without the macro there is no out_err port and no comparison logic.
module mod_addsub_lanes #(
   parameter int K     = 54,
   parameter int LANES = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_op,
   input  logic [LANES*K-1:0] in_a,
   input  logic [LANES*K-1:0] in_b,
   input  logic [K-1:0]       in_q,
   output logic               out_valid,
   input  logic               out_ready,
`ifdef MOD_ADDSUB_RANGE_CHECK_EN
   output logic               out_err,
`endif
   output logic [LANES*K-1:0] out_res
);

   // pipeline control
   logic s1_en;
   logic s2_en;

   // stage 1 state
   logic                   s1_valid_q;
   logic                   s1_op_q;
   logic [K-1:0]           s1_mod_q;
   logic [LANES-1:0][K:0]  s1_r_q;
   logic [LANES-1:0][K:0]  s1_r_d;

   // stage 2 (output) state
   logic                   out_valid_q;
   logic [LANES*K-1:0]     out_res_q;
   logic [LANES*K-1:0]     out_res_d;
   logic [LANES-1:0][K:0]  s2_dif;
   logic [LANES-1:0][K:0]  s2_sum;

`ifdef MOD_ADDSUB_RANGE_CHECK_EN
   logic s1_err_q;
   logic s1_err_d;
   logic out_err_q;
`endif

   // Advance enables: each stage moves when it is empty or its successor moves.
   // in_ready depends only on registered state and out_ready.
   always_comb begin
      s2_en    = !out_valid_q || out_ready;
      s1_en    = !s1_valid_q || s2_en;
      in_ready = s1_en;
   end

   // Stage 1 datapath: K+1-bit add, or zero-extended subtract whose bit K is the borrow.
   always_comb begin
      s1_r_d = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         if (in_op) begin
            s1_r_d[i] = {1'b0, in_a[i*K +: K]} - {1'b0, in_b[i*K +: K]};
         end else begin
            s1_r_d[i] = {1'b0, in_a[i*K +: K]} + {1'b0, in_b[i*K +: K]};
         end
      end
   end

`ifdef MOD_ADDSUB_RANGE_CHECK_EN
   // Operand contract check on the incoming transaction: any lane a/b >= q, or q < 2.
   always_comb begin
      s1_err_d = (in_q[K-1:1] == '0);
      for (int unsigned i = 0; i < LANES; i++) begin
         if ((in_a[i*K +: K] >= in_q) || (in_b[i*K +: K] >= in_q)) begin
            s1_err_d = 1'b1;
         end
      end
   end
`endif

   // Stage 2 datapath: one conditional subtract (add) or add-back (sub) of q.
   always_comb begin
      s2_dif    = '0;
      s2_sum    = '0;
      out_res_d = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         s2_dif[i] = s1_r_q[i] - {1'b0, s1_mod_q};
         s2_sum[i] = s1_r_q[i] + {1'b0, s1_mod_q};
         if (s1_op_q) begin
            // borrow set means a < b: wrap by adding q back
            out_res_d[i*K +: K] = s1_r_q[i][K] ? s2_sum[i][K-1:0] : s1_r_q[i][K-1:0];
         end else begin
            // borrow on r - q means r < q: keep r unchanged
            out_res_d[i*K +: K] = s2_dif[i][K] ? s1_r_q[i][K-1:0] : s2_dif[i][K-1:0];
         end
      end
   end

   // Stage 1 registers: valid follows in_valid whenever S1 may advance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_op_q    <= 1'b0;
         s1_mod_q   <= '0;
         s1_r_q     <= '0;
      end else if (s1_en) begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            s1_op_q  <= in_op;
            s1_mod_q <= in_q;
            s1_r_q   <= s1_r_d;
         end
      end
   end

   // Stage 2 registers: output holds whenever downstream stalls a valid result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_res_q   <= '0;
      end else if (s2_en) begin
         out_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            out_res_q <= out_res_d;
         end
      end
   end

`ifdef MOD_ADDSUB_RANGE_CHECK_EN
   // Error flag travels with its transaction through both stages.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_err_q  <= 1'b0;
         out_err_q <= 1'b0;
      end else begin
         if (s1_en && in_valid) begin
            s1_err_q <= s1_err_d;
         end
         if (s2_en && s1_valid_q) begin
            out_err_q <= s1_err_q;
         end
      end
   end

   assign out_err = out_err_q;
`endif

   assign out_valid = out_valid_q;
   assign out_res   = out_res_q;

endmodule

// File: doc/mod_addsub_lanes.md
Name: mod_addsub_lanes

Overview:
- Multi-lane modular adder/subtractor with a valid/ready elastic pipeline. It is the parametrised successor of the single-lane fixed-latency modular adder.
- Computes (a+b) mod q or (a-b) mod q per transaction across LANES parallel lanes that share one modulus.
- Sits between NTT/RNS datapath stages that can apply backpressure. Sustains full throughput when not stalled.

Parameters:
K, 54, operand and modulus width in bits.
LANES, 4, number of parallel lanes per transaction.

Ports:
clk  in  1  clock, all registers on rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  input transaction valid.
in_ready  out  1  block accepts input this cycle.
in_op  in  1  0 = add, 1 = subtract (a-b).
in_a  in  LANES*K  lane i operand a at bits [i*K +: K].
in_b  in  LANES*K  lane i operand b at bits [i*K +: K].
in_q  in  K  modulus, sampled with the transaction.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts result.
out_res  out  LANES*K  lane i result at bits [i*K +: K].

Behaviour:
- Reset (rst_n low, asynchronous): all valid flags cleared, all data/op/q registers cleared. out_valid=0, out_res=0, in_ready=1 from the first cycle after release.
- Input is unbuffered. Output is fully registered, with no combinational path from in_* to out_*.
- Handshake: a transfer occurs when valid && ready on the same edge.
  - in_valid is ignored while in_ready=0.
  - The source must hold in_* stable until accepted.
  - While out_valid=1 and out_ready=0, out_res and out_valid must hold stable.
- Pipeline: two stages, S1 and S2.
  - S2 advance enable: s2_en = !out_valid || out_ready.
  - S1 advance enable: s1_en = !s1_valid || s2_en.
  - in_ready = s1_en. It depends only on registered state and out_ready.
- Latency: 2 cycles from accept to out_valid when out_ready stays high. Throughput is 1 transaction/cycle.
- S1, per lane:
  - add: r = a + b, width K+1.
  - sub: r = {1'b0,a} - {1'b0,b}, width K+1, so bit K is the borrow.
  - Registers r, op and q.
- S2, per lane:
  - add: c = r - q (K+1 bits). Result = c[K] ? r[K-1:0] : c[K-1:0].
  - sub: result = r[K] ? (r + q)[K-1:0] : r[K-1:0].
- Operand contract: 2 <= q < 2^K and a, b < q. Under this contract the result is always < q. Behaviour outside the contract is a truncated result with no flag, unless the optional feature is compiled in.
- Boundary conditions:
  - a+b == q: result 0.
  - a == b on subtract: result 0.
  - a=0, b=q-1 on subtract: result 1.
  - Maximum width (a=b=q-1 with q near 2^K): no loss in the K+1-bit intermediate.
- Simultaneous events:
  - Accept and emit happen on the same edge when both handshakes fire.
  - Consecutive transactions may change q and op every cycle, because each transaction carries its own q and op.
- Stall: with out_ready=0 and both stages full, in_ready=0. On out_ready rising, in_ready rises in the same cycle and no transaction is lost or duplicated.
- Reset mid-operation flushes all in-flight transactions. No output is produced for them.

Optional Feature:
MOD_ADDSUB_RANGE_CHECK_EN
- With the macro defined:
  - Adds output port out_err (1 bit, per transaction, pipelined alongside out_res).
  - out_err is set if any lane has a >= q or b >= q, or if q < 2.
  - out_err resets to 0, is valid only while out_valid=1, and holds stable under stall.
  - Results are computed unchanged.
- Without the macro: no out_err port and no comparison logic.

Test Plan:
1. K=8, LANES=4, q=251, add, a={0,250,125,100}, b={0,1,126,50} -> out_res={0,0,0,150}, out_valid exactly 2 cycles after accept.
2. q=251, sub, a={0,5,250,7}, b={250,5,0,9} -> out_res={1,0,250,249}.
3. Back-to-back stream of 16 transactions alternating op and q (251, 13) with out_ready=1 -> one result per cycle, in order, each matching a software reference model.
4. Random out_ready stall pattern (~50% duty), 200 random transactions -> out_res/out_valid stable during stall, no drop or duplicate, in_ready=0 only when both stages are full and out_ready=0.
5. Assert rst_n low asynchronously mid-stream with 2 transactions in flight -> out_valid=0 and out_res=0 immediately, no stale output after release, in_ready=1.
6. With MOD_ADDSUB_RANGE_CHECK_EN, q=13, lane 2 a=13 -> out_err=1 on that transaction only. With the macro off, the design elaborates with no out_err port.
